ext_bus_sequencer: RTL and testbench

- Generates the CPU/VIA clock enables and the phi2 bus phase for the 65C02 system.
- Stretches phi2-high by a programmable number of wait-state clocks whenever the current access targets the external data_io bus.
- Sequences external bus cycles: write-data output enable, rwb, and capture of read data at end of phase.
- Internal RAM/ROM/ACIA/VIA accesses run at the fixed base rate.

---
 rtl/ext_bus_sequencer.sv | 100 ++++++++++
 tb/tb_ext_bus_sequencer.sv | 101 ++++++++++
 2 files changed

// File: rtl/ext_bus_sequencer.sv
// ext_bus_sequencer: phi2/clock-enable generator with wait-state stretching for external bus cycles (optional EXT_RDY_EN adds ext_rdy handshake)
module ext_bus_sequencer #(
  parameter int CLKEN_BITS   = 2,
  parameter int WAIT_BITS    = 3,
  parameter int DEFAULT_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 resb,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_we,
  input  logic [7:0]           cpu_dout,
  input  logic                 bus_sel,
  input  logic                 cfg_we,
  input  logic [WAIT_BITS-1:0] cfg_wait,
  input  logic [7:0]           data_in,
`ifdef EXT_RDY_EN
  input  logic                 ext_rdy,
  output logic                 rdy_timeout,
`endif
  output logic [7:0]           data_out,
  output logic                 data_oe,
  output logic                 ext_rwb,
  output logic                 phi2,
  output logic                 cpu_clken,
  output logic                 via_clken,
  output logic [7:0]           rd_data,
  output logic                 busy
);
  localparam int HALF = 2 ** (CLKEN_BITS - 1);
  localparam int CW   = (CLKEN_BITS > 1) ? CLKEN_BITS - 1 : 1;
  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_WAIT} state_t;
  state_t               st, nxt;
  logic [CW-1:0]        ctr;
  logic [WAIT_BITS-1:0] wait_rem, wait_cfg;
  logic                 acc_ext, acc_wr, wr_nxt;
  logic                 last, enter, fin, rdy_hold;
  logic                 unused;
  assign unused = ^cpu_addr;
`ifdef EXT_RDY_EN
  logic [1:0] rdy_s;
  logic [7:0] tcnt;
  logic       hold;
  assign rdy_hold = acc_ext && !rdy_s[1] && tcnt != 8'hFF;
  assign hold = ((st == PH_HIGH && last) || (st == PH_WAIT && wait_rem <= 1)) && rdy_hold;
`else
  assign rdy_hold = 1'b0;
`endif
  // next phase: leave phi2-high once the half-phase and any wait states (and ready hold) are done
  always_comb begin
    last   = ctr == CW'(HALF - 1);
    enter  = st == PH_LOW && last;
    fin    = ((st == PH_HIGH && last && wait_rem == '0) || (st == PH_WAIT && wait_rem <= 1)) && !rdy_hold;
    nxt    = enter ? PH_HIGH : fin ? PH_LOW : (st == PH_HIGH && last) ? PH_WAIT : st;
    wr_nxt = enter ? (bus_sel && cpu_we) : acc_wr;
  end
  // phase sequencer with all bus outputs registered from the next state
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      st        <= PH_LOW;
      ctr       <= '0;
      wait_rem  <= '0;
      wait_cfg  <= WAIT_BITS'(DEFAULT_WAIT);
      acc_ext   <= 1'b0;
      acc_wr    <= 1'b0;
      phi2      <= 1'b0;
      busy      <= 1'b0;
      cpu_clken <= 1'b0;
      via_clken <= 1'b0;
      data_oe   <= 1'b0;
      data_out  <= '0;
      rd_data   <= '0;
      ext_rwb   <= 1'b1;
`ifdef EXT_RDY_EN
      rdy_s       <= '0;
      tcnt        <= '0;
      rdy_timeout <= 1'b0;
`endif
    end else begin
      st        <= nxt;
      ctr       <= (nxt != st) ? '0 : ctr + 1'b1;
      wait_rem  <= enter ? (bus_sel ? wait_cfg : '0) : (st == PH_WAIT && wait_rem != '0) ? wait_rem - 1'b1 : wait_rem;
      wait_cfg  <= cfg_we ? cfg_wait : wait_cfg;
      acc_ext   <= enter ? bus_sel : acc_ext;
      acc_wr    <= wr_nxt;
      phi2      <= nxt != PH_LOW;
      busy      <= nxt == PH_WAIT;
      cpu_clken <= fin;
      via_clken <= cpu_clken;
      data_oe   <= nxt != PH_LOW && wr_nxt;
      ext_rwb   <= !(nxt != PH_LOW && wr_nxt);
      data_out  <= (enter && bus_sel && cpu_we) ? cpu_dout : data_out;
      rd_data   <= (fin && acc_ext && !acc_wr) ? data_in : rd_data;
`ifdef EXT_RDY_EN
      rdy_s       <= {rdy_s[0], ext_rdy};
      tcnt        <= fin ? '0 : hold ? tcnt + 1'b1 : tcnt;
      rdy_timeout <= fin && acc_ext && !rdy_s[1];
`endif
    end
  end
endmodule

// File: tb/tb_ext_bus_sequencer.sv
// tb_ext_bus_sequencer: scoreboard bench measuring each bus cycle between cpu_clken pulses
module tb_ext_bus_sequencer;
  logic        clk = 0, resb = 1, cpu_we = 0, bus_sel = 0, cfg_we = 0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_dout = 0, data_in = 0;
  logic [2:0]  cfg_wait = 0;
  logic [7:0]  data_out, rd_data;
  logic        data_oe, ext_rwb, phi2, cpu_clken, via_clken, busy;
  int          checks = 0, errors = 0;
  typedef struct {int len, hi, bz, oe; logic [7:0] rd, dout;} exp_t;
  exp_t q[$];
  ext_bus_sequencer dut (
    .clk(clk), .resb(resb), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .bus_sel(bus_sel), .cfg_we(cfg_we), .cfg_wait(cfg_wait), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .ext_rwb(ext_rwb), .phi2(phi2),
    .cpu_clken(cpu_clken), .via_clken(via_clken), .rd_data(rd_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // called at a negedge where cpu_clken is high; runs one bus cycle up to the next cpu_clken
  task automatic cyc(input logic sel, input logic we, input logic [7:0] dout, input logic [7:0] din,
                     input int cfgv, input int midv, input int e_len, input int e_hi, input int e_bz,
                     input logic [7:0] e_rd);
    exp_t e;
    int n = 0, hi = 0, bz = 0, oe = 0, rwl = 0, vc = 0;
    logic v1 = 0, md = 0;
    logic [15:0] pat = 0;
    logic [7:0] dq = 0;
    e.len = e_len; e.hi = e_hi; e.bz = e_bz; e.oe = (sel && we) ? e_hi : 0; e.rd = e_rd; e.dout = dout;
    q.push_back(e);
    bus_sel = sel; cpu_we = we; cpu_dout = dout; data_in = din;
    if (cfgv >= 0) begin cfg_we = 1; cfg_wait = 3'(cfgv); end
    do begin
      if (n > 0) cfg_we = 0;
      if (midv >= 0 && busy && !md) begin cfg_we = 1; cfg_wait = 3'(midv); md = 1; end
      hi += int'(phi2); bz += int'(busy); oe += int'(data_oe); rwl += int'(!ext_rwb); vc += int'(via_clken);
      pat = {pat[14:0], phi2};
      if (n == 1) v1 = via_clken;
      if (data_oe) dq = data_out;
      if (phi2) begin bus_sel = 0; cpu_we = !we; end
      n++;
      @(negedge clk);
    end while (!cpu_clken && n < 40);
    cfg_we = 0;
    chk("cycle_bound", n < 40, 1);
    e = q.pop_front();
    chk("len", n, e.len);
    chk("phi2_hi", hi, e.hi);
    chk("busy", bz, e.bz);
    chk("data_oe", oe, e.oe);
    chk("rwb_low", rwl, e.oe);
    chk("phi2_pat", pat, 16'((1 << e.hi) - 1));
    chk("via", {vc[7:0], 7'b0, v1}, {8'd1, 8'd1});
    chk("rd_data", rd_data, e.rd);
    if (e.oe > 0) chk("data_out", dq, e.dout);
  endtask
  initial begin
    int n;
    #2 resb = 0;
    #1 chk("reset", {phi2, busy, cpu_clken, via_clken, data_oe, ext_rwb, data_out, rd_data}, {6'b000001, 16'h0});
    repeat (2) @(negedge clk);
    resb = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_clken && n < 20);
    chk("first_clken", n, 4);
    cyc(0, 0, 8'h00, 8'h11, -1, -1, 4, 2, 0, 8'h00);
    cyc(0, 0, 8'h00, 8'h22, -1, -1, 4, 2, 0, 8'h00);
    cyc(1, 0, 8'h00, 8'hA5, -1, -1, 6, 4, 2, 8'hA5);
    cyc(0, 0, 8'h00, 8'h5A, -1, -1, 4, 2, 0, 8'hA5);
    cyc(1, 1, 8'h3C, 8'h66,  0, -1, 4, 2, 0, 8'hA5);
    cyc(1, 0, 8'h00, 8'h77, -1, -1, 4, 2, 0, 8'h77);
    cyc(0, 0, 8'h00, 8'h00,  2, -1, 4, 2, 0, 8'h77);
    cyc(1, 0, 8'h00, 8'hE1, -1,  5, 6, 4, 2, 8'hE1);
    cyc(1, 1, 8'hC3, 8'h00, -1, -1, 9, 7, 5, 8'hE1);
    cyc(0, 0, 8'h00, 8'h12, -1, -1, 4, 2, 0, 8'hE1);
    bus_sel = 1; cpu_we = 0; data_in = 8'h99;
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 20);
    chk("wait_busy", busy, 1);
    resb = 0;
    #1 chk("reset_mid", {phi2, busy, cpu_clken, via_clken, data_oe, ext_rwb, data_out, rd_data}, {6'b000001, 16'h0});
    bus_sel = 0;
    n = 0;
    repeat (3) begin @(negedge clk); n += int'(cpu_clken); end
    chk("no_clken_rst", n, 0);
    resb = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_clken && n < 20);
    chk("clken_after_rst", n, 4);
    cyc(1, 0, 8'h00, 8'h4B, -1, -1, 6, 4, 2, 8'h4B);
    cyc(0, 0, 8'h00, 8'h00, -1, -1, 4, 2, 0, 8'h4B);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
